mma_tile_sequencer: RTL and testbench
=====================================

// Module: mma_tile_sequencer
// PURPOSE
//  Parametrised tile controller for the systolic tensor-core datapath. Accepts one MMA command
//  (datatype + shape), derives the per-command schedule (A passes, B passes per A, systolic
//  length, INT accumulate), then sequences C/A/B loads, array runs, accumulate and write-back.
//  Adds illegal-shape error, abort and a busy-cycle counter. Sits between the command front-end
//  and the AXI load/store engine plus PE array.
// PARAMETERS
//  ARR_ROWS  8   PE array rows; M rows consumed per A pass
//  ARR_COLS  16  PE array columns; N columns consumed per B pass
//  K_DIM     16  reduction depth per pass
//  FP_LAT    2   PE pipeline latency for FP32/FP16, in cycles
//  INT_LAT   1   PE pipeline latency for INT8/INT4, in cycles
//  ACC_CYC   8   ACCUMULATE cycles per pass, INT only; one per PE regfile entry
//  CNT_W     16  width of the internal cycle counter and of busy_cycles
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-high reset
//  cmd_valid    in   1      command valid
//  cmd_ready    out  1      command accepted when cmd_valid&&cmd_ready
//  cmd_type     in   2      0 FP32, 1 FP16, 2 INT8, 3 INT4
//  cmd_shape    in   2      0 m32n8k16, 1 m16n16k16, 2 m8n32k16, 3 illegal
//  abort        in   1      cancel the current command
//  ld_req       out  1      load request to AXI engine
//  ld_sel       out  2      0 A, 1 B, 2 C
//  ld_idx       out  4      A/C: a-pass index; B: b-pass index
//  ld_ack       in   1      one-cycle load-complete strobe
//  sys_start    out  1      one-cycle pulse on SYSTOLIC entry
//  pattern      out  1      0 NOMAL (FP), 1 BROADCAST (INT8/INT4)
//  acc_en       out  1      high throughout ACCUMULATE
//  wb_req       out  1      D write-back request
//  wb_ack       in   1      one-cycle write-back-complete strobe
//  state        out  4      current state encoding
//  done         out  1      one-cycle pulse on command completion
//  err          out  1      one-cycle pulse on illegal-shape rejection
//  busy_cycles  out  CNT_W  cycles spent outside IDLE by the last command; saturates
// BEHAVIOUR
//  Reset
//   - State is IDLE; every output is 0 except cmd_ready=1.
//   - Reset mid-command drops all requests on the next edge.
//  Command decode (registered at accept)
//   - a_tot = M/ARR_ROWS (m32:4, m16:2, m8:1).
//   - b_tot = max(1, N/ARR_COLS) (n8:1, n16:1, n32:2).
//   - sys_len = ARR_ROWS+ARR_COLS+K_DIM-2+LAT, where LAT is FP_LAT or INT_LAT by cmd_type.
//   - need_acc = cmd_type>=2.
//  Command accept
//   - cmd_ready=1 only in IDLE.
//   - Shape 3: no state change; err pulses in the cycle after accept.
//  States: IDLE=0 READ_C=1 SYSTOLIC=2 ACCUMULATE=3 INIT_WAIT_A=4 INIT_WAIT_B=5 WRITE_BACK=9 FINISH=10
//   - IDLE -> READ_C on a legal accept; a_idx=b_idx=0; busy counter cleared.
//   - READ_C: ld_req=1, ld_sel=C, ld_idx=a_idx. On ld_ack -> INIT_WAIT_A.
//   - INIT_WAIT_A: ld_sel=A, ld_idx=a_idx. On ld_ack -> INIT_WAIT_B.
//   - INIT_WAIT_B: ld_sel=B, ld_idx=b_idx. On ld_ack -> SYSTOLIC.
//   - SYSTOLIC: sys_start pulses in the first cycle. Stays exactly sys_len cycles, then goes to
//     ACCUMULATE if need_acc, else WRITE_BACK.
//   - ACCUMULATE: acc_en=1 for exactly ACC_CYC cycles -> WRITE_BACK.
//   - WRITE_BACK: wb_req=1 until wb_ack. On wb_ack:
//     - b_idx<b_tot-1: b_idx++ -> INIT_WAIT_B (C and A are reused);
//     - else a_idx<a_tot-1: a_idx++, b_idx=0 -> READ_C;
//     - else -> FINISH.
//   - FINISH: done=1 for one cycle -> IDLE.
//  Request handshake
//   - ld_req/wb_req rise on the state-entry edge and stay stable until ack.
//   - Requests fall the cycle after ack.
//   - An ack while no request is outstanding is ignored.
//  Other outputs
//   - pattern holds its decoded value for the whole command.
//  Abort (any non-IDLE state)
//   - Next edge -> IDLE with all requests dropped; done not asserted.
//   - Abort has priority over ld_ack/wb_ack arriving in the same cycle.
//   - Abort in IDLE has no effect.
//  busy_cycles
//   - Counts every cycle in a non-IDLE state, including FINISH.
//   - Saturates at 2^CNT_W-1.
//   - Holds its value in IDLE until the next legal accept.
// TESTING
//  1. FP32 m16n16, immediate acks -> sequence C0,A0,B0,SYS(40 cycles),WB,C1,A1,B0,SYS(40),WB,FINISH;
//     done once; pattern=0; acc_en never high.
//  2. INT8 m8n32 -> C0,A0,B0,SYS(39),ACC(8),WB,B1,SYS(39),ACC(8),WB,done;
//     pattern=1; C/A each fetched once.
//  3. Shape 3 with cmd_valid=1 -> err pulse one cycle after accept; no ld_req; state stays 0;
//     cmd_ready stays 1.
//  4. ld_ack delayed 5 cycles in INIT_WAIT_A -> ld_req/ld_sel/ld_idx stable for all 5 cycles;
//     req drops the cycle after ack.
//  5. abort in the same cycle as wb_ack in the 2nd WRITE_BACK -> IDLE next cycle; no done;
//     new command accepted.
//  6. rst during SYSTOLIC -> all outputs 0 and cmd_ready=1 after the edge; busy_cycles=0.

Source files
------------

// File: rtl/mma_tile_if.sv
// mma_tile_if: command, load-engine, write-back and status signals of the MMA tile sequencer.
interface mma_tile_if #(parameter int CNT_W = 16);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [1:0]       cmd_shape;
    logic             abort;
    logic             ld_req;
    logic [1:0]       ld_sel;
    logic [3:0]       ld_idx;
    logic             ld_ack;
    logic             sys_start;
    logic             pattern;
    logic             acc_en;
    logic             wb_req;
    logic             wb_ack;
    logic [3:0]       state;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] busy_cycles;

    modport slave (
        input  cmd_valid, cmd_type, cmd_shape, abort, ld_ack, wb_ack,
        output cmd_ready, ld_req, ld_sel, ld_idx, sys_start, pattern, acc_en, wb_req,
               state, done, err, busy_cycles
    );

    modport master (
        output cmd_valid, cmd_type, cmd_shape, abort, ld_ack, wb_ack,
        input  cmd_ready, ld_req, ld_sel, ld_idx, sys_start, pattern, acc_en, wb_req,
               state, done, err, busy_cycles
    );
endinterface

// File: rtl/mma_tile_sequencer.sv
// mma_tile_sequencer: schedules C/A/B loads, systolic runs, INT accumulate and write-back for one MMA command.
module mma_tile_sequencer #(
    parameter int ARR_ROWS = 8,
    parameter int ARR_COLS = 16,
    parameter int K_DIM    = 16,
    parameter int FP_LAT   = 2,
    parameter int INT_LAT  = 1,
    parameter int ACC_CYC  = 8,
    parameter int CNT_W    = 16
) (
    input logic     clk,
    input logic     rst,
    mma_tile_if.slave bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_READ_C = 4'd1;
    localparam logic [3:0] S_SYS    = 4'd2;
    localparam logic [3:0] S_ACC    = 4'd3;
    localparam logic [3:0] S_INIT_A = 4'd4;
    localparam logic [3:0] S_INIT_B = 4'd5;
    localparam logic [3:0] S_WB     = 4'd9;
    localparam logic [3:0] S_FIN    = 4'd10;

    localparam logic [CNT_W-1:0] SYS_FP_LAST  = CNT_W'(ARR_ROWS + ARR_COLS + K_DIM - 3 + FP_LAT);
    localparam logic [CNT_W-1:0] SYS_INT_LAST = CNT_W'(ARR_ROWS + ARR_COLS + K_DIM - 3 + INT_LAT);
    localparam logic [CNT_W-1:0] ACC_LAST     = CNT_W'(ACC_CYC - 1);

    logic [3:0]       st, nxt;
    logic [3:0]       a_idx, b_idx, a_last, b_last, a_last_d, b_last_d;
    logic [CNT_W-1:0] sys_last, cnt, busy;
    logic             need_acc, pat, err_q, accept, legal;

    assign accept   = bus.cmd_valid && st == S_IDLE;
    assign legal    = bus.cmd_shape != 2'd3;
    // Schedule sizes are stored as "last index" so the WRITE_BACK compare needs no subtract.
    assign a_last_d = 4'((32 >> bus.cmd_shape) / ARR_ROWS - 1);
    assign b_last_d = ((8 << bus.cmd_shape) / ARR_COLS > 1) ? 4'((8 << bus.cmd_shape) / ARR_COLS - 1) : 4'd0;

    always_comb begin
        nxt = st;
        case (st)
            S_IDLE:   nxt = (accept && legal) ? S_READ_C : S_IDLE;
            S_READ_C: nxt = bus.ld_ack ? S_INIT_A : st;
            S_INIT_A: nxt = bus.ld_ack ? S_INIT_B : st;
            S_INIT_B: nxt = bus.ld_ack ? S_SYS : st;
            S_SYS:    nxt = (cnt == sys_last) ? (need_acc ? S_ACC : S_WB) : st;
            S_ACC:    nxt = (cnt == ACC_LAST) ? S_WB : st;
            S_WB:     nxt = !bus.wb_ack ? st : (b_idx != b_last) ? S_INIT_B :
                            (a_idx != a_last) ? S_READ_C : S_FIN;
            default:  nxt = S_IDLE;
        endcase
        if (bus.abort && st != S_IDLE)
            nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_IDLE;
            a_idx    <= '0;
            b_idx    <= '0;
            a_last   <= '0;
            b_last   <= '0;
            sys_last <= '0;
            need_acc <= 1'b0;
            pat      <= 1'b0;
            cnt      <= '0;
            busy     <= '0;
            err_q    <= 1'b0;
        end else begin
            st    <= nxt;
            err_q <= accept && !legal;
            cnt   <= (nxt != st) ? '0 : cnt + 1'b1;
            if (accept && legal) begin
                a_last   <= a_last_d;
                b_last   <= b_last_d;
                sys_last <= bus.cmd_type[1] ? SYS_INT_LAST : SYS_FP_LAST;
                need_acc <= bus.cmd_type[1];
                pat      <= bus.cmd_type[1];
                a_idx    <= '0;
                b_idx    <= '0;
                busy     <= '0;
            end else if (st != S_IDLE && busy != '1) begin
                busy <= busy + 1'b1;
            end
            if (st == S_WB && nxt == S_INIT_B)
                b_idx <= b_idx + 1'b1;
            if (st == S_WB && nxt == S_READ_C) begin
                a_idx <= a_idx + 1'b1;
                b_idx <= '0;
            end
        end
    end

    assign bus.cmd_ready   = st == S_IDLE;
    assign bus.ld_req      = st == S_READ_C || st == S_INIT_A || st == S_INIT_B;
    assign bus.ld_sel      = st == S_READ_C ? 2'd2 : st == S_INIT_B ? 2'd1 : 2'd0;
    assign bus.ld_idx      = st == S_INIT_B ? b_idx : (st == S_READ_C || st == S_INIT_A) ? a_idx : 4'd0;
    assign bus.sys_start   = st == S_SYS && cnt == '0;
    assign bus.pattern     = pat;
    assign bus.acc_en      = st == S_ACC;
    assign bus.wb_req      = st == S_WB;
    assign bus.state       = st;
    assign bus.done        = st == S_FIN;
    assign bus.err         = err_q;
    assign bus.busy_cycles = busy;
endmodule

// File: tb/tb_mma_tile_sequencer.sv
// tb_mma_tile_sequencer: directed scenarios with hand-computed schedules for the MMA tile sequencer.
module tb_mma_tile_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   log_q[$];
    int   done_cnt, acc_cnt, sys_cnt, pat_or, pat_and;

    mma_tile_if #(.CNT_W(16)) bus();
    mma_tile_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [1:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_shape = s;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Run-length token per state visit: loads = sel*16+idx, SYS 0x100+len, ACC 0x200+len, WB 0x300, FIN 0x400.
    function automatic int tok(input logic [3:0] s, input int run, input int tag);
        return s == 4'd2 ? 'h100 + run : s == 4'd3 ? 'h200 + run : s == 4'd9 ? 'h300 :
               s == 4'd10 ? 'h400 : tag;
    endfunction

    task automatic run_cmd(input logic [1:0] t, input logic [1:0] s);
        logic [3:0] prev;
        int run, tag;
        log_q.delete();
        done_cnt = 0; acc_cnt = 0; sys_cnt = 0; pat_or = 0; pat_and = 1;
        prev = 4'd0; run = 0; tag = 0;
        issue(t, s);
        for (int i = 0; i < 600; i++) begin
            if (bus.state != prev) begin
                if (prev != 4'd0)
                    log_q.push_back(tok(prev, run, tag));
                if (bus.state == 4'd0)
                    break;
                prev = bus.state;
                run  = 0;
                tag  = int'(bus.ld_sel) * 16 + int'(bus.ld_idx);
            end
            run++;
            done_cnt += int'(bus.done);
            acc_cnt  += int'(bus.acc_en);
            sys_cnt  += int'(bus.sys_start);
            pat_or   |= int'(bus.pattern);
            pat_and  &= int'(bus.pattern);
            bus.ld_ack = bus.ld_req;
            bus.wb_ack = bus.wb_req;
            step();
        end
        bus.ld_ack = 1'b0;
        bus.wb_ack = 1'b0;
    endtask

    task automatic test_reset();
        vectors += 4;
        if (bus.state !== 4'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.state); end
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
        if ({bus.ld_req, bus.wb_req, bus.sys_start, bus.acc_en, bus.done, bus.err, bus.pattern} !== 7'd0) begin
            miscompares++; $display("FAIL reset_outputs got %b want 0", {bus.ld_req, bus.wb_req, bus.sys_start, bus.acc_en, bus.done, bus.err, bus.pattern});
        end
        if (bus.busy_cycles !== 16'd0) begin miscompares++; $display("FAIL reset_busy got %0d want 0", bus.busy_cycles); end
    endtask

    task automatic test_fp32_m16n16();
        int exp_q[$] = '{'h20, 'h00, 'h10, 'h128, 'h300, 'h21, 'h01, 'h10, 'h128, 'h300, 'h400};
        run_cmd(2'd0, 2'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            int got = i < log_q.size() ? log_q[i] : -1;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL fp32_seq[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        vectors += 6;
        if (log_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL fp32_seq_len got %0d want %0d", log_q.size(), exp_q.size()); end
        if (done_cnt !== 1) begin miscompares++; $display("FAIL fp32_done got %0d want 1", done_cnt); end
        if (acc_cnt !== 0) begin miscompares++; $display("FAIL fp32_acc got %0d want 0", acc_cnt); end
        if (pat_or !== 0) begin miscompares++; $display("FAIL fp32_pattern got %0d want 0", pat_or); end
        if (sys_cnt !== 2) begin miscompares++; $display("FAIL fp32_sys_start got %0d want 2", sys_cnt); end
        if (bus.busy_cycles !== 16'd89) begin miscompares++; $display("FAIL fp32_busy got %0d want 89", bus.busy_cycles); end
    endtask

    task automatic test_int8_m8n32();
        int exp_q[$] = '{'h20, 'h00, 'h10, 'h127, 'h208, 'h300, 'h11, 'h127, 'h208, 'h300, 'h400};
        run_cmd(2'd2, 2'd2);
        for (int i = 0; i < exp_q.size(); i++) begin
            int got = i < log_q.size() ? log_q[i] : -1;
            vectors++;
            if (got !== exp_q[i]) begin miscompares++; $display("FAIL int8_seq[%0d] got %h want %h", i, got, exp_q[i]); end
        end
        vectors += 5;
        if (done_cnt !== 1) begin miscompares++; $display("FAIL int8_done got %0d want 1", done_cnt); end
        if (acc_cnt !== 16) begin miscompares++; $display("FAIL int8_acc got %0d want 16", acc_cnt); end
        if (pat_and !== 1) begin miscompares++; $display("FAIL int8_pattern got %0d want 1", pat_and); end
        if (bus.busy_cycles !== 16'd101) begin miscompares++; $display("FAIL int8_busy got %0d want 101", bus.busy_cycles); end
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL int8_ready_after got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_illegal_shape();
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd0; bus.cmd_shape = 2'd3;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready_pre got %b want 1", bus.cmd_ready); end
        step();
        bus.cmd_valid = 1'b0;
        vectors += 4;
        if (bus.err !== 1'b1) begin miscompares++; $display("FAIL illegal_err got %b want 1", bus.err); end
        if (bus.state !== 4'd0) begin miscompares++; $display("FAIL illegal_state got %0d want 0", bus.state); end
        if (bus.ld_req !== 1'b0) begin miscompares++; $display("FAIL illegal_ld_req got %b want 0", bus.ld_req); end
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_ready got %b want 1", bus.cmd_ready); end
        step();
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_pulse got %b want 0", bus.err); end
    endtask

    task automatic test_delayed_ack();
        issue(2'd0, 2'd2);
        bus.ld_ack = 1'b1;
        step();
        bus.ld_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({bus.state, bus.ld_req, bus.ld_sel, bus.ld_idx} !== {4'd4, 1'b1, 2'd0, 4'd0}) begin
                miscompares++; $display("FAIL hold_a[%0d] got st=%0d req=%b sel=%0d idx=%0d want st=4 req=1 sel=0 idx=0", i, bus.state, bus.ld_req, bus.ld_sel, bus.ld_idx);
            end
            bus.ld_ack = (i == 4);
            step();
        end
        bus.ld_ack = 1'b0;
        vectors++;
        if ({bus.state, bus.ld_sel} !== {4'd5, 2'd1}) begin
            miscompares++; $display("FAIL after_ack_a got st=%0d sel=%0d want st=5 sel=1", bus.state, bus.ld_sel);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        vectors++;
        if (bus.state !== 4'd0) begin miscompares++; $display("FAIL abort_init_b got %0d want 0", bus.state); end
    endtask

    task automatic test_abort_wb();
        int wbs = 0, dn = 0;
        logic hit = 1'b0;
        issue(2'd0, 2'd1);
        for (int i = 0; i < 300 && !hit; i++) begin
            bus.ld_ack = bus.ld_req;
            bus.wb_ack = bus.wb_req;
            if (bus.wb_req) begin
                wbs++;
                if (wbs == 2) begin bus.abort = 1'b1; hit = 1'b1; end
            end
            dn += int'(bus.done);
            step();
        end
        bus.ld_ack = 1'b0; bus.wb_ack = 1'b0; bus.abort = 1'b0;
        vectors += 3;
        if (!hit) begin miscompares++; $display("FAIL abort_wb_timeout got %0d write-backs want 2", wbs); end
        if (bus.state !== 4'd0) begin miscompares++; $display("FAIL abort_wb_state got %0d want 0", bus.state); end
        if ({bus.wb_req, bus.ld_req} !== 2'b00) begin miscompares++; $display("FAIL abort_wb_reqs got %b want 00", {bus.wb_req, bus.ld_req}); end
        for (int i = 0; i < 3; i++) begin
            dn += int'(bus.done);
            step();
        end
        vectors++;
        if (dn !== 0) begin miscompares++; $display("FAIL abort_wb_done got %0d want 0", dn); end
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd3; bus.cmd_shape = 2'd0;
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_new_ready got %b want 1", bus.cmd_ready); end
        step();
        bus.cmd_valid = 1'b0;
        vectors++;
        if ({bus.state, bus.ld_sel, bus.pattern} !== {4'd1, 2'd2, 1'b1}) begin
            miscompares++; $display("FAIL abort_new_accept got st=%0d sel=%0d pat=%b want st=1 sel=2 pat=1", bus.state, bus.ld_sel, bus.pattern);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic hit = 1'b0;
        issue(2'd2, 2'd1);
        for (int i = 0; i < 50 && !hit; i++) begin
            hit = bus.state == 4'd2;
            bus.ld_ack = bus.ld_req;
            step();
        end
        bus.ld_ack = 1'b0;
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_mid_reach_sys got %0d want 2", bus.state); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors += 4;
        if (bus.state !== 4'd0) begin miscompares++; $display("FAIL rst_mid_state got %0d want 0", bus.state); end
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready got %b want 1", bus.cmd_ready); end
        if ({bus.ld_req, bus.ld_sel, bus.ld_idx, bus.wb_req, bus.sys_start, bus.acc_en, bus.done, bus.err, bus.pattern} !== 13'd0) begin
            miscompares++; $display("FAIL rst_mid_outputs got %b want 0", {bus.ld_req, bus.ld_sel, bus.ld_idx, bus.wb_req, bus.sys_start, bus.acc_en, bus.done, bus.err, bus.pattern});
        end
        if (bus.busy_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_mid_busy got %0d want 0", bus.busy_cycles); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_shape = 2'd0;
        bus.abort = 1'b0; bus.ld_ack = 1'b0; bus.wb_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_fp32_m16n16();
        test_int8_m8n32();
        test_illegal_shape();
        test_delayed_ack();
        test_abort_wb();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
